clint_ctrl: RTL
===============

// Module: clint_ctrl
// PURPOSE
//  Core-local interrupt/exception sequencer next to exe; watches the instruction retiring in exe.
//  On ecall/ebreak, mret, or an enabled external/timer interrupt it holds the pipeline.
//  It then writes mepc/mcause/mstatus through a dedicated csr_file write port.
//  Finally it issues a one-cycle redirect (mtvec or mepc) to pipe_ctrl.
// PARAMETERS
//  DATA_WIDTH      32  data/CSR word width
//  ADDR_WIDTH      32  instruction address width
//  CSR_ADDR_WIDTH  12  CSR address width
// PORTS
//  clk_in           in   1   clock; one clock domain
//  reset_n_in       in   1   asynchronous, active-low reset
//  inst_in          in   32  instruction in exe
//  inst_address_in  in   32  its PC
//  inst_valid_in    in   1   exe holds a real instruction (not bubble)
//  jump_enable_in   in   1   exe redirect this cycle
//  jump_address_in  in   32  exe redirect target
//  stall_busy_in    in   1   exe multi-cycle (m-type) op in progress
//  ext_irq_in       in   1   external interrupt, level
//  timer_irq_in     in   1   timer interrupt, level
//  csr_mstatus_in   in   32  current mstatus (bit3 MIE, bit7 MPIE)
//  csr_mie_in       in   32  current mie (bit11 MEIE, bit7 MTIE)
//  csr_mtvec_in     in   32  current mtvec
//  csr_mepc_in      in   32  current mepc
//  csr_we_out       out  1   CSR write strobe (takes priority over pipeline CSR write)
//  csr_waddr_out    out  12  CSR write address
//  csr_wdata_out    out  32  CSR write data
//  hold_req_out     out  1   to pipe_ctrl: freeze IF/ID/EX
//  int_assert_out   out  1   one-cycle redirect pulse
//  int_addr_out     out  32  redirect target
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; latched cause/epc 0. Reset mid-sequence aborts at once; no partial CSR write completes afterwards.
//  Event qualify (IDLE only): inst_valid_in=1 and stall_busy_in=0.
//   Priority: ECALL(0x00000073) > EBREAK(0x00100073) > MRET(0x30200073) > EXT(MIE&MEIE&ext_irq_in) > TIMER(MIE&MTIE&timer_irq_in).
//  Latched on accept:
//   ECALL cause=11, epc=inst_address_in; EBREAK cause=3, epc=inst_address_in.
//   EXT cause=0x8000000B, TIMER cause=0x80000007; epc = jump_enable_in ? jump_address_in : inst_address_in+4.
//   The exe instruction still completes.
//  hold_req_out: combinational 1 in the accept cycle; registered 1 in every non-IDLE state.
//  Trap FSM: IDLE -> W_MEPC -> W_MCAUSE -> W_MSTATUS -> T_ASSERT -> IDLE, one state per cycle.
//   W_MEPC: we=1, addr=0x341, data=epc.
//   W_MCAUSE: we=1, addr=0x342, data=cause.
//   W_MSTATUS: we=1, addr=0x300, data=mstatus with MPIE=MIE, MIE=0.
//   T_ASSERT: int_assert_out=1, int_addr_out={csr_mtvec_in[31:2],2'b00}.
//  MRET FSM: IDLE -> R_MSTATUS -> R_ASSERT -> IDLE.
//   R_MSTATUS: we=0x300 write, data=mstatus with MIE=MPIE, MPIE=1.
//   R_ASSERT: int_assert_out=1, int_addr_out=csr_mepc_in.
//  Latency: accept to int_assert_out = 4 cycles (trap), 2 cycles (mret). int_assert_out never exceeds 1 cycle.
//  Outside write states csr_we_out=0 and addr/data=0; int_addr_out=0 except in assert states.
//  Events arriving while busy are ignored; level irqs re-evaluate in IDLE after the assert cycle.
//   MIE is already 0 after a trap, so no nesting.
//  Simultaneous ecall+irq: ecall taken; irq stays pending. Bubble or m-stall in exe: no accept.
//  All arithmetic 32-bit wrapping (PC+4 at 0xFFFFFFFC wraps to 0).
// STRUCTURE
//  Shared defines.v: CSR addresses (MEPC/MCAUSE/MSTATUS/MTVEC), cause codes, ECALL/EBREAK/MRET encodings, FSM state codes.
//  One sub-module: clint_evt_prio (combinational qualify + priority pick -> event id, cause, epc); FSM/regs in clint_ctrl.
// TESTING
//  ecall @PC=0x100, mtvec=0x200, mstatus=0x8 -> mepc=0x100, mcause=11, mstatus=0x80 on cycles 1-3; pulse cycle 4 addr=0x200.
//  MIE=1, MEIE=1, ext_irq_in=1, exe addi @0x40, no jump -> mepc=0x44, mcause=0x8000000B.
//  Same with jump_enable_in=1 target 0x80 -> mepc=0x80.
//  mret, mepc=0x44, mstatus=0x80 -> write mstatus=0x88; next cycle pulse addr=0x44; total 2 cycles.
//  ext_irq_in=1 while stall_busy_in=1 for 3 cycles -> no hold_req_out until busy drops; MIE=0 -> never taken.
//  ext and timer together -> cause 0x8000000B; reset_n_in=0 during W_MCAUSE -> all outputs 0 immediately, IDLE, no later writes.

Source files
------------

// File: rtl/clint_ctrl_pkg.sv
// rtl/clint_ctrl_pkg.sv - shared CSR addresses, cause codes, encodings and state types for clint_ctrl
package clint_ctrl_pkg;

  // CSR addresses written or read by the sequencer
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mcause values; bit 31 marks an interrupt
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  // Full-word encodings of the system instructions we react to
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // Bit positions inside mstatus / mie
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIE_MTIE     = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MSTATUS,
    ST_T_ASSERT,
    ST_R_MSTATUS,
    ST_R_ASSERT
  } state_t;

  typedef enum logic [2:0] {
    EVT_NONE,
    EVT_ECALL,
    EVT_EBREAK,
    EVT_MRET,
    EVT_EXT,
    EVT_TIMER
  } evt_t;

endpackage

// File: rtl/clint_evt_prio.sv
// rtl/clint_evt_prio.sv - qualifies the exe instruction/irqs and picks the highest-priority event
module clint_evt_prio
  import clint_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [31:0]           inst_in,
  input  logic [ADDR_WIDTH-1:0] inst_address_in,
  input  logic                  inst_valid_in,
  input  logic                  jump_enable_in,
  input  logic [ADDR_WIDTH-1:0] jump_address_in,
  input  logic                  stall_busy_in,
  input  logic                  ext_irq_in,
  input  logic                  timer_irq_in,
  input  logic                  mstatus_mie,
  input  logic                  mie_meie,
  input  logic                  mie_mtie,
  output evt_t                  evt,
  output logic [DATA_WIDTH-1:0] evt_cause,
  output logic [ADDR_WIDTH-1:0] evt_epc
);

  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] irq_epc;

  // Interrupts resume at whatever exe would have done next: the redirect target or PC+4 (wrapping)
  always_comb begin
    pc_next = inst_address_in + ADDR_WIDTH'(4);
    irq_epc = jump_enable_in ? jump_address_in : pc_next;
  end

  // Fixed priority pick; only a real, non-stalled instruction in exe can be interrupted or trap
  always_comb begin
    evt       = EVT_NONE;
    evt_cause = '0;
    evt_epc   = '0;
    if (inst_valid_in && !stall_busy_in) begin
      if (inst_in == INST_ECALL) begin
        evt       = EVT_ECALL;
        evt_cause = DATA_WIDTH'(CAUSE_ECALL);
        evt_epc   = inst_address_in;
      end else if (inst_in == INST_EBREAK) begin
        evt       = EVT_EBREAK;
        evt_cause = DATA_WIDTH'(CAUSE_EBREAK);
        evt_epc   = inst_address_in;
      end else if (inst_in == INST_MRET) begin
        evt       = EVT_MRET;
      end else if (mstatus_mie && mie_meie && ext_irq_in) begin
        evt       = EVT_EXT;
        evt_cause = DATA_WIDTH'(CAUSE_EXT);
        evt_epc   = irq_epc;
      end else if (mstatus_mie && mie_mtie && timer_irq_in) begin
        evt       = EVT_TIMER;
        evt_cause = DATA_WIDTH'(CAUSE_TIMER);
        evt_epc   = irq_epc;
      end
    end
  end

endmodule

// File: rtl/clint_ctrl.sv
// rtl/clint_ctrl.sv - core-local trap/interrupt sequencer: holds pipe, writes CSRs, redirects
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic [31:0]               inst_in,
  input  logic [ADDR_WIDTH-1:0]     inst_address_in,
  input  logic                      inst_valid_in,
  input  logic                      jump_enable_in,
  input  logic [ADDR_WIDTH-1:0]     jump_address_in,
  input  logic                      stall_busy_in,
  input  logic                      ext_irq_in,
  input  logic                      timer_irq_in,
  input  logic [DATA_WIDTH-1:0]     csr_mstatus_in,
  input  logic [DATA_WIDTH-1:0]     csr_mie_in,
  input  logic [DATA_WIDTH-1:0]     csr_mtvec_in,
  input  logic [DATA_WIDTH-1:0]     csr_mepc_in,
  output logic                      csr_we_out,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_out,
  output logic [DATA_WIDTH-1:0]     csr_wdata_out,
  output logic                      hold_req_out,
  output logic                      int_assert_out,
  output logic [ADDR_WIDTH-1:0]     int_addr_out
);

  state_t                state;
  evt_t                  evt;
  logic [DATA_WIDTH-1:0] evt_cause;
  logic [ADDR_WIDTH-1:0] evt_epc;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] mstatus_trap;
  logic [DATA_WIDTH-1:0] mstatus_mret;

  clint_evt_prio #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_evt_prio (
    .inst_in         (inst_in),
    .inst_address_in (inst_address_in),
    .inst_valid_in   (inst_valid_in),
    .jump_enable_in  (jump_enable_in),
    .jump_address_in (jump_address_in),
    .stall_busy_in   (stall_busy_in),
    .ext_irq_in      (ext_irq_in),
    .timer_irq_in    (timer_irq_in),
    .mstatus_mie     (csr_mstatus_in[MSTATUS_MIE]),
    .mie_meie        (csr_mie_in[MIE_MEIE]),
    .mie_mtie        (csr_mie_in[MIE_MTIE]),
    .evt             (evt),
    .evt_cause       (evt_cause),
    .evt_epc         (evt_epc)
  );

  // mstatus images: trap entry saves MIE into MPIE and disables; mret restores MIE and sets MPIE
  always_comb begin
    mstatus_trap               = csr_mstatus_in;
    mstatus_trap[MSTATUS_MPIE] = csr_mstatus_in[MSTATUS_MIE];
    mstatus_trap[MSTATUS_MIE]  = 1'b0;
    mstatus_mret               = csr_mstatus_in;
    mstatus_mret[MSTATUS_MIE]  = csr_mstatus_in[MSTATUS_MPIE];
    mstatus_mret[MSTATUS_MPIE] = 1'b1;
  end

  // Hold the pipe combinationally in the accept cycle, and for as long as a sequence runs
  always_comb begin
    hold_req_out = (state != ST_IDLE) || (evt != EVT_NONE);
  end

  // Sequencer FSM; CSR/redirect outputs are registered so each is valid for exactly its state
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state          <= ST_IDLE;
      cause_q        <= '0;
      csr_we_out     <= 1'b0;
      csr_waddr_out  <= '0;
      csr_wdata_out  <= '0;
      int_assert_out <= 1'b0;
      int_addr_out   <= '0;
    end else begin
      csr_we_out     <= 1'b0;
      csr_waddr_out  <= '0;
      csr_wdata_out  <= '0;
      int_assert_out <= 1'b0;
      int_addr_out   <= '0;
      case (state)
        ST_IDLE: begin
          case (evt)
            EVT_ECALL, EVT_EBREAK, EVT_EXT, EVT_TIMER: begin
              state         <= ST_W_MEPC;
              cause_q       <= evt_cause;
              csr_we_out    <= 1'b1;
              csr_waddr_out <= CSR_ADDR_WIDTH'(CSR_MEPC);
              csr_wdata_out <= DATA_WIDTH'(evt_epc);
            end
            EVT_MRET: begin
              state         <= ST_R_MSTATUS;
              csr_we_out    <= 1'b1;
              csr_waddr_out <= CSR_ADDR_WIDTH'(CSR_MSTATUS);
              csr_wdata_out <= mstatus_mret;
            end
            default: state <= ST_IDLE;
          endcase
        end
        ST_W_MEPC: begin
          state         <= ST_W_MCAUSE;
          csr_we_out    <= 1'b1;
          csr_waddr_out <= CSR_ADDR_WIDTH'(CSR_MCAUSE);
          csr_wdata_out <= cause_q;
        end
        ST_W_MCAUSE: begin
          state         <= ST_W_MSTATUS;
          csr_we_out    <= 1'b1;
          csr_waddr_out <= CSR_ADDR_WIDTH'(CSR_MSTATUS);
          csr_wdata_out <= mstatus_trap;
        end
        ST_W_MSTATUS: begin
          state          <= ST_T_ASSERT;
          int_assert_out <= 1'b1;
          int_addr_out   <= ADDR_WIDTH'({csr_mtvec_in[DATA_WIDTH-1:2], 2'b00});
        end
        ST_R_MSTATUS: begin
          state          <= ST_R_ASSERT;
          int_assert_out <= 1'b1;
          int_addr_out   <= ADDR_WIDTH'(csr_mepc_in);
        end
        ST_T_ASSERT, ST_R_ASSERT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
